hsv2rgb_pipe: RTL and testbench

//  Parametrised, fully pipelined HSV->RGB colour-space converter for the video path.

---
 rtl/hsv2rgb_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_hsv2rgb_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb_pipe.sv
// ---------------------------------------------------------------------------
// hsv2rgb_pipe
//
// Fully pipelined HSV -> RGB colour-space converter for the video path.
// Three register stages with a fixed latency of 3 enabled cycles. Valid, hsync
// and vsync travel alongside the pixel so they are never skewed against it.
// Hues of 360 or more are flagged and passed through as grey (R=G=B=V).
//
// Build option:
//   HSV2RGB_ROUND_EN  defined   -> both divisions (by MAXV and by 60) round half-up
//                     undefined -> both divisions truncate (floor), default build
//
// Ports:
//   clk_Image_Process  in   1       pixel clock, rising edge
//   Rst                in   1       asynchronous, active-low reset
//   Pipe_En            in   1       1 = pipeline advances, 0 = every stage holds
//   In_Valid           in   1       pixel qualifier for HSV_Data_*
//   In_Hsync           in   1       line sync, delayed with the data
//   In_Vsync           in   1       frame sync, delayed with the data
//   HSV_Data_H         in   9       hue in degrees, legal range 0..359
//   HSV_Data_S         in   DATA_W  saturation 0..MAXV
//   HSV_Data_V         in   DATA_W  value 0..MAXV
//   Out_Valid          out  1       In_Valid delayed by the pipeline
//   Out_Hsync          out  1       In_Hsync delayed by the pipeline
//   Out_Vsync          out  1       In_Vsync delayed by the pipeline
//   RGB_Data_R/G/B     out  DATA_W  colour channels
//   Out_H_Err          out  1       1 = this pixel had H >= 360
//   Delay_Num          out  3       constant pipeline latency
// ---------------------------------------------------------------------------
module hsv2rgb_pipe #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk_Image_Process,
    input  logic              Rst,
    input  logic              Pipe_En,
    input  logic              In_Valid,
    input  logic              In_Hsync,
    input  logic              In_Vsync,
    input  logic [8:0]        HSV_Data_H,
    input  logic [DATA_W-1:0] HSV_Data_S,
    input  logic [DATA_W-1:0] HSV_Data_V,
    output logic              Out_Valid,
    output logic              Out_Hsync,
    output logic              Out_Vsync,
    output logic [DATA_W-1:0] RGB_Data_R,
    output logic [DATA_W-1:0] RGB_Data_G,
    output logic [DATA_W-1:0] RGB_Data_B,
    output logic              Out_H_Err,
    output logic [2:0]        Delay_Num
);

    localparam int unsigned MAXV = (2 ** DATA_W) - 1;
    // One spare bit on each product keeps the rounding bias from ever overflowing.
    localparam int unsigned PW   = 2 * DATA_W + 1;
    localparam int unsigned AW   = DATA_W + 7;

`ifdef HSV2RGB_ROUND_EN
    localparam int unsigned MIN_BIAS = MAXV / 2;
    localparam int unsigned ADJ_BIAS = 30;
`else
    localparam int unsigned MIN_BIAS = 0;
    localparam int unsigned ADJ_BIAS = 0;
`endif

    // -----------------------------------------------------------------------
    // Sideband: valid / hsync / vsync shift with the data, one bit per stage
    // -----------------------------------------------------------------------
    logic [2:0] vld_q, hs_q, vs_q;

    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            vld_q <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
        end else if (Pipe_En) begin
            vld_q <= {vld_q[1:0], In_Valid};
            hs_q  <= {hs_q[1:0],  In_Hsync};
            vs_q  <= {vs_q[1:0],  In_Vsync};
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: min = V*(MAXV-S)/MAXV, hue sector, offset within sector, range flag
    // -----------------------------------------------------------------------
    logic [PW-1:0]     min_num;
    logic [DATA_W-1:0] v1_d, min1_d;
    logic [2:0]        sec1_d;
    logic [5:0]        hmod1_d;
    logic              herr1_d;

    logic [DATA_W-1:0] v1_q, min1_q;
    logic [2:0]        sec1_q;
    logic [5:0]        hmod1_q;
    logic              herr1_q;

    always_comb begin
        min_num = PW'(HSV_Data_V) * (PW'(MAXV) - PW'(HSV_Data_S)) + PW'(MIN_BIAS);
        v1_d    = HSV_Data_V;
        min1_d  = DATA_W'(min_num / PW'(MAXV));
        // Sector is only meaningful for legal hues; out-of-range hues are
        // overridden by herr in stage 3, so the truncation to 3 bits is harmless.
        sec1_d  = 3'(HSV_Data_H / 9'd60);
        hmod1_d = 6'(HSV_Data_H % 9'd60);
        herr1_d = (HSV_Data_H >= 9'd360);
    end

    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            v1_q    <= '0;
            min1_q  <= '0;
            sec1_q  <= '0;
            hmod1_q <= '0;
            herr1_q <= 1'b0;
        end else if (Pipe_En) begin
            v1_q    <= v1_d;
            min1_q  <= min1_d;
            sec1_q  <= sec1_d;
            hmod1_q <= hmod1_d;
            herr1_q <= herr1_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: adj = (V-min)*hmod/60
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] delta2;
    logic [AW-1:0]     adj_num;
    logic [DATA_W-1:0] adj2_d;

    logic [DATA_W-1:0] v2_q, min2_q, adj2_q;
    logic [2:0]        sec2_q;
    logic              herr2_q;

    always_comb begin
        delta2  = v1_q - min1_q;
        adj_num = AW'(delta2) * AW'(hmod1_q) + AW'(ADJ_BIAS);
        // adj <= delta always (hmod <= 59), so the result fits in DATA_W bits.
        adj2_d  = DATA_W'(adj_num / AW'(60));
    end

    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            v2_q    <= '0;
            min2_q  <= '0;
            adj2_q  <= '0;
            sec2_q  <= '0;
            herr2_q <= 1'b0;
        end else if (Pipe_En) begin
            v2_q    <= v1_q;
            min2_q  <= min1_q;
            adj2_q  <= adj2_d;
            sec2_q  <= sec1_q;
            herr2_q <= herr1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: per-sector channel select, registered outputs
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] up3, dn3;
    logic [DATA_W-1:0] r3_d, g3_d, b3_d;
    logic [DATA_W-1:0] r3_q, g3_q, b3_q;
    logic              herr3_q;

    always_comb begin
        // min+adj <= V and V-adj >= min, so neither can wrap.
        up3  = min2_q + adj2_q;
        dn3  = v2_q - adj2_q;
        r3_d = v2_q;
        g3_d = v2_q;
        b3_d = v2_q;
        if (!herr2_q) begin
            case (sec2_q)
                3'd0: begin r3_d = v2_q;   g3_d = up3;    b3_d = min2_q; end
                3'd1: begin r3_d = dn3;    g3_d = v2_q;   b3_d = min2_q; end
                3'd2: begin r3_d = min2_q; g3_d = v2_q;   b3_d = up3;    end
                3'd3: begin r3_d = min2_q; g3_d = dn3;    b3_d = v2_q;   end
                3'd4: begin r3_d = up3;    g3_d = min2_q; b3_d = v2_q;   end
                3'd5: begin r3_d = v2_q;   g3_d = min2_q; b3_d = dn3;    end
                default: begin r3_d = v2_q; g3_d = v2_q;  b3_d = v2_q;   end
            endcase
        end
    end

    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            r3_q    <= '0;
            g3_q    <= '0;
            b3_q    <= '0;
            herr3_q <= 1'b0;
        end else if (Pipe_En) begin
            r3_q    <= r3_d;
            g3_q    <= g3_d;
            b3_q    <= b3_d;
            herr3_q <= herr2_q;
        end
    end

    assign RGB_Data_R = r3_q;
    assign RGB_Data_G = g3_q;
    assign RGB_Data_B = b3_q;
    assign Out_H_Err  = herr3_q;
    assign Out_Valid  = vld_q[2];
    assign Out_Hsync  = hs_q[2];
    assign Out_Vsync  = vs_q[2];
    assign Delay_Num  = 3'(LATENCY);

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
module tb_hsv2rgb_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pipe_en;
    logic       in_valid, in_hs, in_vs;
    logic [8:0] h;
    logic [7:0] s, v;
    logic       out_valid, out_hs, out_vs, out_err;
    logic [7:0] r, g, b;
    logic [2:0] dly;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef HSV2RGB_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        int h, s, v, r, g, b, e;
    } vec_t;

    vec_t tv[12];

    hsv2rgb_pipe #(.DATA_W(8), .LATENCY(3)) dut (
        .clk_Image_Process(clk),
        .Rst              (rst_n),
        .Pipe_En          (pipe_en),
        .In_Valid         (in_valid),
        .In_Hsync         (in_hs),
        .In_Vsync         (in_vs),
        .HSV_Data_H       (h),
        .HSV_Data_S       (s),
        .HSV_Data_V       (v),
        .Out_Valid        (out_valid),
        .Out_Hsync        (out_hs),
        .Out_Vsync        (out_vs),
        .RGB_Data_R       (r),
        .RGB_Data_G       (g),
        .RGB_Data_B       (b),
        .Out_H_Err        (out_err),
        .Delay_Num        (dly)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input int ev, input int ehs, input int evs,
                          input int er, input int eg, input int eb, input int ee);
        chk({tag, ".valid"}, int'(out_valid), ev);
        chk({tag, ".hsync"}, int'(out_hs), ehs);
        chk({tag, ".vsync"}, int'(out_vs), evs);
        chk({tag, ".R"}, int'(r), er);
        chk({tag, ".G"}, int'(g), eg);
        chk({tag, ".B"}, int'(b), eb);
        chk({tag, ".herr"}, int'(out_err), ee);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int hh, input int ss, input int vv,
                         input bit vl, input bit hs, input bit vs);
        h        = 9'(hh);
        s        = 8'(ss);
        v        = 8'(vv);
        in_valid = vl;
        in_hs    = hs;
        in_vs    = vs;
    endtask

    task automatic drive_vec(input int i, input bit hs, input bit vs);
        drive(tv[i].h, tv[i].s, tv[i].v, 1'b1, hs, vs);
    endtask

    task automatic chk_vec(input string tag, input int i, input int ehs, input int evs);
        chk_px(tag, 1, ehs, evs, tv[i].r, tv[i].g, tv[i].b, tv[i].e);
    endtask

    initial begin
        // Hand-computed vectors: H, S, V -> R, G, B, herr
        tv[0]  = '{0,   255, 255, 255, 0,   0,   0};
        tv[1]  = '{30,  255, 255, 255, RND ? 128 : 127, 0, 0};
        tv[2]  = '{359, 255, 255, 255, 0,   RND ? 4 : 5, 0};
        tv[3]  = '{120, 255, 200, 0,   200, 0,   0};
        tv[4]  = '{200, 0,   77,  77,  77,  77,  0};
        tv[5]  = '{400, 200, 90,  90,  90,  90,  1};
        tv[6]  = '{360, 255, 255, 255, 255, 255, 1};
        tv[7]  = '{180, 128, 200, RND ? 100 : 99, 200, 200, 0};
        tv[8]  = '{90,  255, 100, 50,  100, 0,   0};
        tv[9]  = '{250, 100, 180, RND ? 121 : 120, 109, 180, 0};
        tv[10] = '{300, 50,  0,   0,   0,   0,   0};
        tv[11] = '{59,  255, 255, 255, RND ? 251 : 250, 0, 0};

        rst_n   = 1'b0;
        pipe_en = 1'b1;
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
        #12;
        chk_px("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("delay_num", int'(dly), 3);
        rst_n = 1'b1;
        tick();

        // Single pixel: appears after exactly three edges, not before
        drive_vec(0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lat_early.valid", int'(out_valid), 0);
        tick();
        chk_vec("lat3", 0, 0, 0);

        // Back-to-back stream of all vectors, syncs patterned by index
        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive_vec(i, 1'(i & 1), 1'((i >> 1) & 1));
            else        drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i >= 2) chk_vec($sformatf("stream%0d", i - 2), i - 2, (i - 2) & 1, ((i - 2) >> 1) & 1);
        end
        tick();
        chk("stream_end.valid", int'(out_valid), 0);

        // Burst with a two-cycle stall; hsync on the second pixel, vsync on the first
        drive_vec(0, 1'b0, 1'b1);
        tick();
        drive_vec(3, 1'b1, 1'b0);
        tick();
        drive_vec(4, 1'b0, 1'b0);
        tick();
        chk_vec("burst_p0", 0, 0, 1);
        pipe_en = 1'b0;
        drive(10, 1, 3, 1'b0, 1'b1, 1'b1);
        tick();
        chk_vec("stall1_p0", 0, 0, 1);
        tick();
        chk_vec("stall2_p0", 0, 0, 1);
        pipe_en = 1'b1;
        drive_vec(8, 1'b0, 1'b0);
        tick();
        chk_vec("burst_p1", 3, 1, 0);
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_vec("burst_p2", 4, 0, 0);
        tick();
        chk_vec("burst_p3", 8, 0, 0);
        tick();
        chk("burst_end.valid", int'(out_valid), 0);

        // Reset mid-burst: outputs clear at once, in-flight pixels are dropped
        drive_vec(0, 1'b1, 1'b1);
        tick();
        drive_vec(3, 1'b0, 1'b0);
        tick();
        drive_vec(4, 1'b0, 1'b0);
        tick();
        chk_vec("pre_rst_p0", 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_px("async_rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_px("held_rst", 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        drive_vec(9, 1'b0, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_rst_flush.valid", int'(out_valid), 0);
        chk("post_rst_flush.R", int'(r), 0);
        tick();
        chk_vec("post_rst_p", 9, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
